// File: rtl/control_unit_if.sv
// Instruction fetch port of the J17 sequencer.
// Request is held until the memory acknowledges with a word.
interface control_unit_if;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] instr_data;

  modport master (
    output instr_req,
    input  instr_ack,
    input  instr_data
  );

  modport slave (
    input  instr_req,
    output instr_ack,
    output instr_data
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the J17 datapath.
// Fetch over req/ack, decode, then strobe the datapath controls.
module control_unit (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  control_unit_if.master imem,
  output logic [3:0]     opcode,
  output logic [31:0]    op1,
  output logic [31:0]    op2,
  output logic           imControl,
  output logic           regenable,
  output logic           ramenable,
  output logic [1:0]     pcControl,
  output logic [1:0]     writecode,
  output logic           busy,
  output logic           halted,
  output logic           error,
  output logic [15:0]    instret
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        req_q;
  logic [3:0]  op_q;
  logic [1:0]  cls_q;
  logic [31:0] w;
  logic        fire;
  logic        illegal;
  logic        retire;

  assign w       = imem.instr_data;
  assign fire    = (state == S_FETCH) && req_q && imem.instr_ack;
  assign illegal = (cls_q == 2'b11) && (op_q > 4'd2);

  assign imem.instr_req = req_q;
  assign busy   = (state != S_IDLE) && (state != S_HALT)
               && (state != S_ERROR);
  assign halted = (state == S_HALT);
  assign error  = (state == S_ERROR);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Registered fetch request: rises a cycle into FETCH, drops after ack.
  always_ff @(posedge clock) begin
    if (reset)                         req_q <= 1'b0;
    else if (state == S_FETCH && !req_q) req_q <= 1'b1;
    else if (fire)                     req_q <= 1'b0;
  end

  // Latch instruction fields; they stay put from DECODE to retire.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q      <= 4'd0;
      cls_q     <= 2'd0;
      opcode    <= 4'd0;
      op1       <= 32'd0;
      op2       <= 32'd0;
      imControl <= 1'b0;
    end else if (fire) begin
      op_q      <= w[31:28];
      cls_q     <= w[27:26];
      opcode    <= w[27] ? 4'd0 : w[31:28];
      op1       <= {27'b0, w[25:21]};
      op2       <= (w[27:26] == 2'b00) ? {27'b0, w[4:0]}
                                       : {11'b0, w[20:0]};
      imControl <= (w[27:26] != 2'b00);
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clock) begin
    if (reset)       instret <= 16'd0;
    else if (retire) instret <= instret + 16'd1;
  end

  // Next-state and per-cycle datapath strobes.
  always_comb begin
    state_n   = state;
    regenable = 1'b0;
    ramenable = 1'b0;
    pcControl = 2'd2;
    writecode = 2'd0;
    retire    = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_n = S_FETCH;
      S_FETCH:  if (fire) state_n = S_DECODE;
      S_DECODE: state_n = illegal ? S_ERROR : S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          (cls_q == 2'b00): begin
            regenable = 1'b1;
            pcControl = 2'd0;
            retire    = 1'b1;
            state_n   = S_FETCH;
          end
          (cls_q == 2'b01): begin
            regenable = 1'b1;
            writecode = (op_q == 4'd0) ? 2'd1 : 2'd0;
            pcControl = 2'd0;
            retire    = 1'b1;
            state_n   = S_FETCH;
          end
          (cls_q == 2'b10): begin
            ramenable = 1'b1;
            state_n   = S_MEM;
          end
          (cls_q == 2'b11): begin
            retire = 1'b1;
            if (op_q == 4'd0) pcControl = 2'd0;
            if (op_q == 4'd1) pcControl = 2'd1;
            state_n = (op_q == 4'd2) ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        ramenable = 1'b1;
        regenable = 1'b1;
        writecode = 2'd2;
        pcControl = 2'd0;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      S_ERROR: state_n = S_ERROR;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit.
// Expected strobes come from an instruction-level model.
module tb_control_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        imControl;
  logic        regenable;
  logic        ramenable;
  logic [1:0]  pcControl;
  logic [1:0]  writecode;
  logic        busy;
  logic        halted;
  logic        error;
  logic [15:0] instret;

  control_unit_if bus ();

  control_unit dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .imem(bus),
    .opcode(opcode),
    .op1(op1),
    .op2(op2),
    .imControl(imControl),
    .regenable(regenable),
    .ramenable(ramenable),
    .pcControl(pcControl),
    .writecode(writecode),
    .busy(busy),
    .halted(halted),
    .error(error),
    .instret(instret)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        re;
    logic        ram;
    logic [1:0]  wc;
    logic [1:0]  pc;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [3:0]  opc;
    logic        imc;
    logic        imc_chk;
    logic [15:0] ir;
  } rec_t;

  rec_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] mcnt = 16'd0;
  int          exp_gap = -1;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Instruction-level reference: which strobe cycles the word yields.
  task automatic model_push(input logic [31:0] wd, output int gap);
    logic [3:0] op;
    logic [1:0] cls;
    rec_t r;
    op  = wd[31:28];
    cls = wd[27:26];
    r.o1  = {27'b0, wd[25:21]};
    r.o2  = (cls == 2'd0) ? {27'b0, wd[4:0]} : {11'b0, wd[20:0]};
    r.opc = (cls < 2'd2) ? op : 4'd0;
    r.re = 1'b0; r.ram = 1'b0; r.wc = 2'd0; r.pc = 2'd2;
    r.imc = 1'b1; r.imc_chk = 1'b1; r.ir = mcnt;
    gap = 3;
    case (cls)
      2'd0: begin
        r.re = 1'b1; r.pc = 2'd0; r.imc = 1'b0;
        q.push_back(r); mcnt++;
      end
      2'd1: begin
        r.re = 1'b1; r.pc = 2'd0;
        r.wc = (op == 4'd0) ? 2'd1 : 2'd0;
        q.push_back(r); mcnt++;
      end
      2'd2: begin
        r.ram = 1'b1;
        q.push_back(r);
        r.re = 1'b1; r.wc = 2'd2; r.pc = 2'd0;
        q.push_back(r); mcnt++;
        gap = 4;
      end
      default: begin
        if (op == 4'd0) begin
          r.pc = 2'd0; r.imc_chk = 1'b0;
          q.push_back(r); mcnt++;
        end else if (op == 4'd1) begin
          r.pc = 2'd1;
          q.push_back(r); mcnt++;
        end else if (op == 4'd2) begin
          mcnt++; gap = -1;
        end else begin
          gap = -1;
        end
      end
    endcase
  endtask

  function automatic logic [31:0] rand_instr();
    logic [1:0] cls;
    logic [3:0] op;
    cls = 2'($urandom_range(0, 3));
    op  = (cls == 2'd3) ? 4'($urandom_range(0, 1))
                        : 4'($urandom_range(0, 15));
    return {op, cls, 26'($urandom)};
  endfunction

  // Waits for instr_req; acks while req is low must be ignored.
  task automatic wait_req(output int zeros);
    zeros = 0;
    while (bus.instr_req !== 1'b1 && zeros < 50) begin
      bus.instr_ack  = 1'($urandom_range(0, 1));
      bus.instr_data = 32'h3C00_0000;
      @(posedge clock); #1;
      zeros++;
    end
    bus.instr_ack = 1'b0;
    if (bus.instr_req !== 1'b1) begin
      total++; bad++;
      $display("FAIL req_timeout: got %b want 1", bus.instr_req);
    end
  endtask

  task automatic issue(input logic [31:0] wd, input int waits);
    int z;
    int g;
    wait_req(z);
    if (bus.instr_req !== 1'b1) return;
    if (exp_gap >= 0) chk("fetch_gap", 32'(z), 32'(exp_gap));
    for (int i = 0; i < waits; i++) begin
      @(posedge clock); #1;
      chk("req_held", 32'(bus.instr_req), 32'd1);
    end
    bus.instr_ack  = 1'b1;
    bus.instr_data = wd;
    model_push(wd, g);
    @(posedge clock); #1;
    bus.instr_ack  = 1'b0;
    bus.instr_data = $urandom;
    exp_gap = g;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    exp_gap = -1;
  endtask

  task automatic wait_flag(input bit want_err);
    int n;
    n = 0;
    while ((want_err ? error : halted) !== 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic do_reset();
    chk("queue_drained", 32'(q.size()), 32'd0);
    reset = 1'b1;
    start = 1'b0;
    bus.instr_ack = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    mcnt = 16'd0;
    exp_gap = -1;
    q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(bus.instr_req), 32'd0);
    chk({tag, "_opcode"}, 32'(opcode), 32'd0);
    chk({tag, "_op1"}, op1, 32'd0);
    chk({tag, "_op2"}, op2, 32'd0);
    chk({tag, "_imc"}, 32'(imControl), 32'd0);
    chk({tag, "_strobes"}, {28'd0, regenable, ramenable, writecode},
        32'd0);
    chk({tag, "_pc"}, 32'(pcControl), 32'd2);
    chk({tag, "_flags"}, {29'd0, busy, halted, error}, 32'd0);
    chk({tag, "_instret"}, 32'(instret), 32'd0);
  endtask

  // Monitor: every strobe cycle must match the next expected record.
  always @(negedge clock) begin
    rec_t e;
    if (mon_en && reset === 1'b0 && (regenable === 1'b1
        || ramenable === 1'b1 || pcControl !== 2'd2)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL strobe_extra: got re=%b ram=%b pc=%0d want none",
                 regenable, ramenable, pcControl);
      end else begin
        e = q.pop_front();
        if (regenable !== e.re || ramenable !== e.ram
            || writecode !== e.wc || pcControl !== e.pc
            || op1 !== e.o1 || op2 !== e.o2 || opcode !== e.opc
            || (e.imc_chk && imControl !== e.imc)
            || instret !== e.ir) begin
          bad++;
          $display({"FAIL strobe: got re=%b ram=%b wc=%0d pc=%0d op1=%0h",
                    " op2=%0h opc=%0h imc=%b ir=%0h want re=%b ram=%b",
                    " wc=%0d pc=%0d op1=%0h op2=%0h opc=%0h imc=%b ir=%0h"},
                   regenable, ramenable, writecode, pcControl, op1, op2,
                   opcode, imControl, instret, e.re, e.ram, e.wc, e.pc,
                   e.o1, e.o2, e.opc, e.imc, e.ir);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int z;
    bus.instr_ack  = 1'b0;
    bus.instr_data = 32'd0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    mon_en = 1'b1;
    chk_reset_vals("rst");

    pulse_start();
    issue(32'h1400_0125, 0);
    issue(32'h0860_0040, 0);
    issue(32'h1C00_0010, 0);
    issue(32'h1400_0125, 3);
    repeat (150) issue(rand_instr(), $urandom_range(0, 3));
    issue(32'h2C00_0000, $urandom_range(0, 2));
    wait_flag(1'b0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_pc", 32'(pcControl), 32'd2);
    chk("halt_instret", 32'(instret), 32'(mcnt));
    pulse_start();
    repeat (4) begin @(posedge clock); #1; end
    chk("halt_sticky", {30'd0, halted, bus.instr_req}, 32'd2);

    do_reset();
    pulse_start();
    issue(rand_instr(), 0);
    issue(rand_instr(), 1);
    issue({4'($urandom_range(3, 15)), 2'b11, 26'($urandom)}, 0);
    wait_flag(1'b1);
    chk("err_flag", 32'(error), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_pc", 32'(pcControl), 32'd2);
    chk("err_instret", 32'(instret), 32'(mcnt));

    do_reset();
    pulse_start();
    issue(32'h1400_0125, 0);
    wait_req(z);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_reset_vals("midreset");
    reset = 1'b0;
    q.delete();
    mcnt = 16'd0;
    repeat (3) begin @(posedge clock); #1; end
    chk("idle_after_reset", {30'd0, busy, bus.instr_req}, 32'd0);

    do_reset();
    force dut.instret = 16'hFFFE;
    @(posedge clock); #1;
    release dut.instret;
    mcnt = 16'hFFFE;
    pulse_start();
    issue({4'($urandom_range(1, 15)), 2'b00, 26'($urandom)}, 0);
    issue({4'($urandom_range(0, 15)), 2'b01, 26'($urandom)}, 0);
    wait_req(z);
    chk("wrap_gap", 32'(z), 32'd3);
    chk("wrap_instret", 32'(instret), 32'd0);
    exp_gap = -1;
    issue(32'h2C00_0000, 0);
    wait_flag(1'b0);
    chk("wrap_halt_instret", 32'(instret), 32'd1);
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the J17 datapath. Fetches a 32-bit instruction word over a req/ack handshake, decodes it, and drives the datapath control inputs for exactly the cycles each instruction needs: one-cycle register writes, one PC update per instruction, and an extra wait cycle for RAM loads. Sits between the instruction memory, which is addressed directly by the datapath PC, and the DATAPATH control/operand inputs. Also reports halt, illegal-instruction and retired-instruction status.

## Interface
- No parameters; all widths fixed.
- clock  in  1  processor clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; leaves IDLE.
- instr_req  out  1  fetch request to instruction memory.
- instr_ack  in  1  instruction memory has put `instr_data` on the bus this cycle.
- instr_data  in  32  fetched instruction word.
- opcode  out  4  ALU operation to datapath.
- op1  out  32  destination/source register index, zero-extended.
- op2  out  32  register index, immediate, RAM address, or jump target.
- imControl  out  1  1 = `op2` is an immediate.
- regenable  out  1  register write strobe; one cycle.
- ramenable  out  1  RAM address enable.
- pcControl  out  2  0 = PC+1, 1 = PC←op2, 2 = hold.
- writecode  out  2  register write source: 0 = ALU, 1 = op2, 2 = RAM result.
- busy  out  1  high in every state except IDLE, HALT and ERROR.
- halted  out  1  in HALT.
- error  out  1  in ERROR.
- instret  out  16  retired-instruction count.

## Operation
- Instruction fields:
  - `[31:28]` = `op`.
  - `[27:26]` = class.
  - `[25:21]` = `rd`.
  - `[20:0]` = `imm`.
  - `[4:0]` = `rs`.
- Field latching:
  - The instruction register is latched on the first cycle with `instr_req` and `instr_ack` both high.
  - `op1 = {27'b0, rd}`.
  - `op2 = {27'b0, rs}` for class 00; `{11'b0, imm}` otherwise.
  - `opcode = op` for classes 00 and 01; 0 otherwise.
- Classes:
  - 00 ALU reg: `imControl=0`. EXEC drives `regenable=1`, `writecode=0`, `pcControl=0`.
  - 01 ALU imm: same as 00 with `imControl=1`. `op` 4'd0 combined with `writecode=1` is load-immediate: EXEC selects `writecode=1` when `op==0`, else `writecode=0`.
  - 10 LOAD: `imControl=1`.
    - EXEC drives `ramenable=1`.
    - MEM drives `ramenable=1`, `regenable=1`, `writecode=2`, `pcControl=0`.
  - 11 CTRL:
    - `op` 0 = NOP: EXEC drives `pcControl=0`.
    - `op` 1 = JMP: EXEC drives `pcControl=1`, `imControl=1`.
    - `op` 2 = HALT: no PC change; go to HALT.
    - `op` 3–15 = illegal: go to ERROR.
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT, ERROR.
  - IDLE → FETCH on `start`.
  - FETCH → DECODE on `instr_ack`.
  - DECODE → EXEC, or → ERROR if illegal.
  - EXEC → MEM for LOAD, → HALT for HALT, else → FETCH.
  - MEM → FETCH.
  - HALT and ERROR are sticky until `reset`.
- Output defaults in every state/cycle not listed above: `regenable=0`, `ramenable=0`, `pcControl=2`, `writecode=0`.
- `instret` increments by 1 on the cycle an instruction completes: EXEC for non-LOAD, MEM for LOAD, EXEC for HALT. It wraps from 16'hFFFF to 0. Illegal instructions do not count.

## Timing
- Reset values:
  - State IDLE.
  - `instr_req=0`, `opcode=0`, `op1=0`, `op2=0`, `imControl=0`.
  - `regenable=0`, `ramenable=0`, `pcControl=2`, `writecode=0`.
  - `busy=0`, `halted=0`, `error=0`, `instret=0`.
- `reset` overrides everything, including a mid-fetch request. `instr_req` is 0 on the cycle after `reset` is sampled.
- `instr_req` is registered:
  - Rises the cycle after entering FETCH.
  - Held until `instr_ack` is sampled.
  - Drops the next cycle.
- `instr_ack` while `instr_req=0` is ignored.
- Latency with zero-wait ack (ack in the first request cycle):
  - ALU, JMP and NOP: 4 cycles, FETCH ×2 + DECODE + EXEC.
  - LOAD: 5 cycles.
  - Each extra wait cycle adds 1.
- Operand, opcode and `imControl` outputs are stable from DECODE through EXEC/MEM so the datapath sees settled values at the strobe edge.
- Exactly one non-hold `pcControl` cycle per retired instruction. HALT and illegal instructions never advance the PC.
- `start` outside IDLE is ignored.

## Test plan
- Reset, then `start`; ack word 32'h1400_0125 (op1 ADD, class 01, rd 0, imm 0x125) → `regenable` high for exactly one cycle with `op1=0`, `op2=0x125`, `imControl=1`, `writecode=0`, `pcControl=0`; `instret=1`.
- Fetch with ack delayed 3 cycles → `instr_req` held for 4 cycles, no strobes until after DECODE, then completes normally.
- LOAD word 32'h0860_0040 (class 10, rd 3, imm 0x40) → EXEC `ramenable=1`, `op2=0x40`; MEM `regenable=1`, `writecode=2`, `pcControl=0`; 5 cycles total.
- JMP word 32'h1C00_0010 (op 1, class 11, imm 0x10) → one cycle `pcControl=1`, `op2=0x10`, no `regenable`.
- HALT word 32'h2C00_0000 → `halted=1`, `busy=0`, `pcControl=2`, further `start` ignored. Illegal word 32'h3C00_0000 → `error=1`, `instret` unchanged.
- `reset` asserted while `instr_req=1` → next cycle IDLE with all outputs at reset values. Preload `instret` to 16'hFFFF by running instructions; one more retire → `instret=0`.
